// File: rtl/mips_pkg.sv
// Shared types and instruction-field positions for the 5-stage MIPS pipeline.
package mips_pkg;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] word_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int RD_HI = 15;
    localparam int RD_LO = 11;

    // Register 0 is hardwired, so a write aimed at it must never be forwarded.
    function automatic logic wb_hit(input logic we, input reg_addr_t wa, input reg_addr_t ra);
        return we && (wa != REG_ZERO) && (wa == ra);
    endfunction

endpackage

// File: rtl/wb_bypass.sv
// Zero-safe writeback-to-decode bypass for one register file read port.
module wb_bypass
    import mips_pkg::*;
(
    input  logic [4:0]  ra,
    input  logic [31:0] rd,
    input  logic        we_w,
    input  logic [4:0]  wa_w,
    input  logic [31:0] wd_w,
    output logic [31:0] data
);

    assign data = wb_hit(we_w, wa_w, ra) ? wd_w : rd;

endmodule

// File: rtl/id_ex_issue.sv
// Decode-to-execute issue stage: operand bypass, load-use detection,
// the ID/EX pipeline register and a saturating stall-cycle counter.
module id_ex_issue
    import mips_pkg::*;
#(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_d,
    input  logic [31:0]       instr_d,
    input  logic [31:0]       imm_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic              regwrite_d,
    input  logic              memread_d,
    input  logic              uses_rt_d,
    output logic [4:0]        ra1,
    output logic [4:0]        ra2,
    input  logic [31:0]       rd1,
    input  logic [31:0]       rd2,
    input  logic              we_w,
    input  logic [4:0]        wa_w,
    input  logic [31:0]       wd_w,
    input  logic              hold,
    input  logic              flush_e,
    output logic              stall_d,
    output logic              valid_e,
    output logic              regwrite_e,
    output logic              memread_e,
    output logic [4:0]        rs_e,
    output logic [4:0]        rt_e,
    output logic [4:0]        rd_e,
    output logic [31:0]       a_e,
    output logic [31:0]       b_e,
    output logic [31:0]       imm_e,
    output logic [CTRL_W-1:0] ctrl_e,
    output logic [CNT_W-1:0]  stall_cnt
);

    word_t a_d;
    word_t b_d;
    logic  lu;
    logic  bubble;

    assign ra1 = instr_d[RS_HI:RS_LO];
    assign ra2 = instr_d[RT_HI:RT_LO];

    wb_bypass u_byp_a (.ra(ra1), .rd(rd1), .we_w(we_w), .wa_w(wa_w), .wd_w(wd_w), .data(a_d));
    wb_bypass u_byp_b (.ra(ra2), .rd(rd2), .we_w(we_w), .wa_w(wa_w), .wd_w(wd_w), .data(b_d));

    // The load's rt is its destination; rt only matters to the consumer when it is a source.
    assign lu = valid_d & valid_e & memread_e & (rt_e != REG_ZERO)
              & ((rt_e == ra1) | (uses_rt_d & (rt_e == ra2)));

    assign stall_d = lu | hold;
    assign bubble  = lu & ~hold & ~flush_e;

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_e    <= 1'b0;
            regwrite_e <= 1'b0;
            memread_e  <= 1'b0;
            rs_e       <= '0;
            rt_e       <= '0;
            rd_e       <= '0;
            a_e        <= '0;
            b_e        <= '0;
            imm_e      <= '0;
            ctrl_e     <= '0;
        end else if (flush_e || (lu && !hold)) begin
            // Killing only the control bits is enough; the datapath fields are don't-care.
            valid_e    <= 1'b0;
            regwrite_e <= 1'b0;
            memread_e  <= 1'b0;
        end else if (!hold) begin
            valid_e    <= valid_d;
            regwrite_e <= regwrite_d & valid_d;
            memread_e  <= memread_d & valid_d;
            rs_e       <= instr_d[RS_HI:RS_LO];
            rt_e       <= instr_d[RT_HI:RT_LO];
            rd_e       <= instr_d[RD_HI:RD_LO];
            a_e        <= a_d;
            b_e        <= b_d;
            imm_e      <= imm_d;
            ctrl_e     <= ctrl_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (bubble && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: doc/id_ex_issue.md
Name: id_ex_issue

Overview:
- Decode-to-execute issue stage of the 5-stage pipelined MIPS core.
- Drives the register file read addresses from the IF/ID instruction.
- Bypasses same-cycle writeback data over the file's read data and detects load-use hazards.
- Owns the ID/EX pipeline register, with stall, bubble, hold and flush, plus a saturating stall-cycle counter.

Parameters:
- CTRL_W, 8: width of the opaque EX/MEM/WB control bundle, carried unchanged.
- CNT_W, 16: width of the stall-cycle performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- valid_d  in  1  IF/ID slot holds a real instruction.
- instr_d  in  32  instruction in decode.
- imm_d  in  32  sign/zero-extended immediate from the decoder.
- ctrl_d  in  CTRL_W  decoded control bundle.
- regwrite_d  in  1  decoded instruction writes a register.
- memread_d  in  1  decoded instruction is a load.
- uses_rt_d  in  1  decoded instruction reads rt as a source.
- ra1, ra2  out  5  register file read addresses, combinational: instr_d[25:21] and instr_d[20:16].
- rd1, rd2  in  32  register file read data.
- we_w, wa_w, wd_w  in  1/5/32  writeback port, same signals that drive the register file write.
- hold  in  1  downstream freeze; ID/EX keeps its contents.
- flush_e  in  1  kill the instruction entering EX (taken branch/jump).
- stall_d  out  1  freeze PC and IF/ID, combinational.
- valid_e, regwrite_e, memread_e  out  1 each  registered.
- rs_e, rt_e, rd_e  out  5 each  registered: instr[25:21], instr[20:16], instr[15:11].
- a_e, b_e, imm_e  out  32 each  registered operands and immediate.
- ctrl_e  out  CTRL_W  registered control bundle.
- stall_cnt  out  CNT_W  count of load-use bubble cycles.

Behaviour:
- Reset (reset=0, asynchronous): all ID/EX outputs are 0 and stall_cnt is 0. With valid_e=0, stall_d drops to 0 unless hold=1.
- Bypass, combinational: a_d is wd_w when we_w=1, wa_w!=0 and wa_w==ra1; otherwise a_d is rd1. b_d follows the same rule with ra2 and rd2. Register 0 is never bypassed, and a write with wa_w=0 is ignored.
- Load-use hazard: lu = valid_d & valid_e & memread_e & (rt_e!=0) & ((rt_e==ra1) | (uses_rt_d & rt_e==ra2)).
- stall_d = lu | hold.
- ID/EX update at each rising edge, first matching rule wins:
  - 1. flush_e=1: valid_e, regwrite_e and memread_e go to 0; the datapath fields may hold any value. This rule wins over hold and lu.
  - 2. hold=1: all fields keep their values.
  - 3. lu=1: bubble; valid_e, regwrite_e and memread_e go to 0, other fields don't-care. IF/ID is frozen externally by stall_d, so the dependent instruction re-decodes next cycle. Latency is exactly one bubble per load-use pair.
  - 4. Otherwise: load valid_d, regwrite_d&valid_d, memread_d&valid_d, the rs/rt/rd fields, a_d, b_d, imm_d and ctrl_d.
- An invalid slot (valid_d=0) loads with regwrite_e=0 and memread_e=0, so it never creates a hazard.
- stall_cnt increments by 1 on each edge where rule 3 fires, and saturates at all-ones (no wrap). Hold and flush cycles are not counted.
- Back-to-back loads: a second load dependent on the first gets one bubble, then issues normally.
- A load whose rt is 0 never stalls.
- Reset asserted mid-stall clears the bubble state immediately; there is no pending stall after release.
- No internal FSM beyond the ID/EX register and the counter. The hazard decision depends only on current inputs and the registered EX fields.

Decomposition:
- Shared package mips_pkg holds:
  - typedef reg_addr_t as logic[4:0], and typedef word_t as logic[31:0];
  - constant REG_ZERO = 5'd0;
  - the instruction field position constants RS_HI/RS_LO, RT_HI/RT_LO, RD_HI/RD_LO.
- One natural sub-module, wb_bypass: the combinational zero-safe writeback bypass. It is instantiated twice, once per read port.
- The ID/EX register, hazard logic and counter stay in id_ex_issue.

Test Plan:
- Writeback bypass:
  - Stimulus: rd1=0x11111111, ra1=5, we_w=1, wa_w=5, wd_w=0xDEADBEEF.
  - Required: a_e=0xDEADBEEF one edge later.
  - With wa_w=0 and ra1=0, a_e follows rd1 instead.
- Load-use via rt:
  - Stimulus: lw into r8 issued, then add r9 reading rt=r8 with uses_rt_d=1.
  - Required: stall_d=1 for one cycle; the next edge yields valid_e=0 and stall_cnt=1; the add issues on the following edge with valid_e=1.
- No false stall:
  - Case 1: lw into r0 followed by a reader of r0.
  - Case 2: sw-style instruction with uses_rt_d=0 whose rt matches.
  - Required in both cases: stall_d=0 and stall_cnt unchanged.
- Flush priority:
  - Stimulus: flush_e=1 asserted together with hold=1 and lu=1.
  - Required: next edge gives valid_e=0, regwrite_e=0, memread_e=0; stall_cnt is unchanged.
- Hold:
  - Stimulus: hold=1 for 3 cycles while valid_d changes.
  - Required: all E outputs remain bit-identical and stall_d=1 throughout.
- Reset and saturation:
  - Stimulus: force 2^CNT_W+5 load-use bubbles (CNT_W=4 build).
  - Required: stall_cnt stops at 0xF.
  - Then assert reset=0 asynchronously mid-cycle. Required: all outputs are 0 before the next edge.
